// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for the bit-serial add/subtract controller.
// The requester drives the i* side; the controller drives the o* side.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             iStart;
    logic             iSub;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oBusy;
    logic             oDone;
    logic [WIDTH-1:0] oSum;
    logic             oCout;
    logic             oOvf;

    modport master (
        output iStart, iSub, iA, iB,
        input  oBusy, oDone, oSum, oCout, oOvf
    );

    modport slave (
        input  iStart, iSub, iA, iB,
        output oBusy, oDone, oSum, oCout, oOvf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one internal full-adder stage is stepped LSB first for
// WIDTH cycles, then sum, carry-out and signed overflow are presented with a done strobe.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    serial_add_ctrl_if.slave sa_if
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_load;
    logic             w_shift;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-2:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_acc_full;

    // 1-bit full adder on the current LSBs and the running carry.
    assign w_fa_sum   = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_fa_cout  = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));
    assign w_acc_full = {w_fa_sum, r_acc};

    // NOTE: sequential state is always written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (sa_if.iStart) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_shift = 1'b1;
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // NOTE: the datapath has no storage arrays, so clearing every register on reset is cheap
    // and keeps a mid-operation abort from leaking stale operands.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with iSub.
            r_a_sr  <= sa_if.iA;
            r_b_sr  <= sa_if.iB ^ {WIDTH{sa_if.iSub}};
            r_acc   <= '0;
            r_carry <= sa_if.iSub;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_a_sr  <= r_a_sr >> 1;
            r_b_sr  <= r_b_sr >> 1;
            r_acc   <= w_acc_full[WIDTH-1:1];
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Result registers move only on the edge entering DONE and hold across later runs.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_acc_full;
            r_cout <= w_fa_cout;
            r_ovf  <= r_carry ^ w_fa_cout;
        end
    end

    assign sa_if.oBusy = (r_state != ST_IDLE);
    assign sa_if.oDone = (r_state == ST_DONE);
    assign sa_if.oSum  = r_sum;
    assign sa_if.oCout = r_cout;
    assign sa_if.oOvf  = r_ovf;

    a_done_one_cycle: assert property (
        @(posedge iClk) disable iff (!iRst_n) sa_if.oDone |=> !sa_if.oDone
    );

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: an arithmetic reference model predicts each result
// and its completion cycle; a negedge monitor compares whatever the DUT presents.
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           due;
    } exp_t;

    logic clk;
    logic rst_n;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .sa_if  (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    int   m_rem   = 0;
    exp_t exp_q[$];
    exp_t held;
    bit   b2b_phase = 1'b0;
    int   done_cycles[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Reference arithmetic from plain integer rules: modulo sum, unsigned carry/no-borrow,
    // and signed range overflow.
    function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t e;
        int ua, ub, sa, sb, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            r      = ua + ub;
            sr     = sa + sb;
            e.cout = (r >= (1 << W));
        end else begin
            r      = ua - ub;
            sr     = sa - sb;
            e.cout = (ua >= ub);
        end
        e.sum = r[W-1:0];
        e.ovf = (sr > ((1 << (W - 1)) - 1)) || (sr < -(1 << (W - 1)));
        e.due = 0;
        return e;
    endfunction

    // Timing model: an accepted start keeps the block busy for WIDTH RUN cycles plus one DONE.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0;
            exp_q.delete();
            held.sum  = '0;
            held.cout = 1'b0;
            held.ovf  = 1'b0;
            held.due  = 0;
        end else begin
            cycle++;
            if (m_rem == 0) begin
                if (bus.iStart) begin
                    exp_t e;
                    e     = ref_op(bus.iA, bus.iB, bus.iSub);
                    e.due = cycle + W;
                    exp_q.push_back(e);
                    m_rem = W + 1;
                end
            end else begin
                m_rem--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", {31'd0, bus.oBusy}, {31'd0, m_rem != 0});
            if (bus.oDone) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", {31'd0, bus.oDone}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cycle, e.due);
                    check("sum", {24'd0, bus.oSum}, {24'd0, e.sum});
                    check("cout", {31'd0, bus.oCout}, {31'd0, e.cout});
                    check("ovf", {31'd0, bus.oOvf}, {31'd0, e.ovf});
                    held = e;
                    if (b2b_phase) done_cycles.push_back(cycle);
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
                    check("done_missing", {31'd0, bus.oDone}, 32'd1);
                    held = exp_q.pop_front();
                end else begin
                    check("sum_hold", {24'd0, bus.oSum}, {24'd0, held.sum});
                    check("cout_hold", {31'd0, bus.oCout}, {31'd0, held.cout});
                    check("ovf_hold", {31'd0, bus.oOvf}, {31'd0, held.ovf});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cycle);
        $fatal(1, "watchdog");
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int n;
        n = 0;
        @(negedge clk);
        while (m_rem != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("start_wait_idle", m_rem, 0);
        bus.iStart = 1'b1;
        bus.iA     = a;
        bus.iB     = b;
        bus.iSub   = sub;
        @(negedge clk);
        bus.iStart = 1'b0;
        bus.iA     = W'($urandom);
        bus.iB     = W'($urandom);
        bus.iSub   = 1'($urandom);
    endtask

    task automatic wait_result(input logic [W-1:0] s, input logic c, input logic o, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.oDone && lat < 50);
        check("dir_done", {31'd0, bus.oDone}, 32'd1);
        check("dir_sum", {24'd0, bus.oSum}, {24'd0, s});
        check("dir_cout", {31'd0, bus.oCout}, {31'd0, c});
        check("dir_ovf", {31'd0, bus.oOvf}, {31'd0, o});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_rem != 0 || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", m_rem, 0);
    endtask

    initial begin
        int lat;
        bus.iStart = 1'b0;
        bus.iSub   = 1'b0;
        bus.iA     = '0;
        bus.iB     = '0;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;
        #2;
        check("rst_busy", {31'd0, bus.oBusy}, 32'd0);
        check("rst_done", {31'd0, bus.oDone}, 32'd0);
        check("rst_sum", {24'd0, bus.oSum}, 32'd0);
        check("rst_cout", {31'd0, bus.oCout}, 32'd0);
        check("rst_ovf", {31'd0, bus.oOvf}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic corners.
        start_op(8'h5A, 8'h33, 1'b0);
        wait_result(8'h8D, 1'b0, 1'b1, lat);
        check("latency_add", lat, W);
        start_op(8'hFF, 8'h01, 1'b0);
        wait_result(8'h00, 1'b1, 1'b0, lat);
        start_op(8'h7F, 8'h01, 1'b0);
        wait_result(8'h80, 1'b0, 1'b1, lat);
        start_op(8'h10, 8'h20, 1'b1);
        wait_result(8'hF0, 1'b0, 1'b0, lat);
        start_op(8'h80, 8'h01, 1'b1);
        wait_result(8'h7F, 1'b1, 1'b1, lat);

        // Start pulses during RUN and DONE must be ignored.
        start_op(8'h01, 8'h01, 1'b0);
        @(negedge clk);
        bus.iStart = 1'b1; bus.iA = 8'hAA; bus.iB = 8'h55;
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (6) @(negedge clk);
        bus.iStart = 1'b1; bus.iA = 8'hAA; bus.iB = 8'h55;
        @(negedge clk);
        bus.iStart = 1'b0;
        check("ignored_sum", {24'd0, bus.oSum}, 32'h02);
        repeat (3) @(negedge clk);
        check("ignored_no_restart", {31'd0, bus.oBusy}, 32'd0);

        // Reset mid-operation aborts; first edge after release accepts a new start.
        start_op(8'h33, 8'h44, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.oBusy}, 32'd0);
        check("abort_done", {31'd0, bus.oDone}, 32'd0);
        check("abort_sum", {24'd0, bus.oSum}, 32'd0);
        check("abort_cout", {31'd0, bus.oCout}, 32'd0);
        check("abort_ovf", {31'd0, bus.oOvf}, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        bus.iStart = 1'b1; bus.iA = 8'h01; bus.iB = 8'h02; bus.iSub = 1'b0;
        @(negedge clk);
        bus.iStart = 1'b0;
        wait_result(8'h03, 1'b0, 1'b0, lat);
        check("latency_after_reset", lat, W);

        // iStart held high with operands changing every cycle.
        wait_idle();
        b2b_phase = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.iStart = 1'b1;
            bus.iA     = W'($urandom);
            bus.iB     = W'($urandom);
            bus.iSub   = 1'($urandom);
        end
        @(negedge clk);
        bus.iStart = 1'b0;
        wait_idle();
        b2b_phase = 1'b0;
        check("b2b_count_ge5", {31'd0, done_cycles.size() >= 5}, 32'd1);
        for (int i = 1; i < done_cycles.size(); i++) begin
            check("b2b_spacing", done_cycles[i] - done_cycles[i-1], W + 2);
        end

        // Randomized add/subtract against the reference model.
        for (int i = 0; i < 1000; i++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        check("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
